// File: rtl/dma_hold_arbiter.sv
// dma_hold_arbiter: hands the bus from the CPU to the DMA controller via the CPU hold handshake.
// Define HOLD_TIMEOUT_EN to force a release once a grant has lasted MAX_HOLD cycles.
module dma_hold_arbiter #(
    parameter int GRANT_DELAY = 2,
    parameter int RELEASE_GAP = 1,
    parameter int CNT_W       = 16,
    parameter int MAX_HOLD    = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hrq,
    output logic             hlda,
    input  logic             cpu_bus_busy,
    input  logic             cpu_lock_n,
    output logic             cpu_hold,
    input  logic             cpu_hold_ack,
    output logic             bus_owner,
    output logic [CNT_W-1:0] hold_cycles,
    output logic             timeout_err
);

`ifdef HOLD_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int DLY_W = (GRANT_DELAY > 1) ? $clog2(GRANT_DELAY + 1) : 1;
    localparam int GAP_W = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

    typedef enum logic [2:0] {
        IDLE,
        REQ_CPU,
        TURN_ON,
        GRANTED,
        TURN_OFF,
        GAP
    } state_t;

    state_t           state;
    logic [DLY_W-1:0] dly;
    logic [GAP_W-1:0] gap;
    logic [CNT_W-1:0] hold_next;

    // Saturating increment so a very long grant never wraps back to a small count.
    assign hold_next = (&hold_cycles) ? hold_cycles : hold_cycles + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dly         <= '0;
            gap         <= '0;
            hlda        <= 1'b0;
            cpu_hold    <= 1'b0;
            bus_owner   <= 1'b0;
            hold_cycles <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hrq && cpu_lock_n && !cpu_bus_busy) begin
                        state    <= REQ_CPU;
                        cpu_hold <= 1'b1;
                    end
                end
                REQ_CPU: begin
                    if (!hrq) begin
                        state <= TURN_OFF;
                    end else if (cpu_hold_ack) begin
                        hold_cycles <= '0;
                        if (GRANT_DELAY == 0) begin
                            state     <= GRANTED;
                            hlda      <= 1'b1;
                            bus_owner <= 1'b1;
                        end else begin
                            state <= TURN_ON;
                            dly   <= DLY_W'(GRANT_DELAY);
                        end
                    end
                end
                TURN_ON: begin
                    if (!hrq) begin
                        state <= TURN_OFF;
                    end else if (dly == DLY_W'(1)) begin
                        state     <= GRANTED;
                        hlda      <= 1'b1;
                        bus_owner <= 1'b1;
                    end else begin
                        dly <= dly - DLY_W'(1);
                    end
                end
                GRANTED: begin
                    hold_cycles <= hold_next;
                    if (!hrq) begin
                        state     <= TURN_OFF;
                        hlda      <= 1'b0;
                        bus_owner <= 1'b0;
                    end else if (TIMEOUT_EN && hold_next == MAX_HOLD_C) begin
                        state       <= TURN_OFF;
                        hlda        <= 1'b0;
                        bus_owner   <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                TURN_OFF: begin
                    // CPU hold stays up one extra cycle so the DMA side can float the bus.
                    cpu_hold <= 1'b0;
                    if (RELEASE_GAP == 0) begin
                        state <= IDLE;
                    end else begin
                        state <= GAP;
                        gap   <= GAP_W'(RELEASE_GAP);
                    end
                end
                GAP: begin
                    if (gap == GAP_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        gap <= gap - GAP_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    hlda      <= 1'b0;
                    cpu_hold  <= 1'b0;
                    bus_owner <= 1'b0;
                end
            endcase
        end
    end

endmodule
